// File: rtl/captura_coordenada_if.sv
// Coordinate-capture bus: switch/button inputs toward the capture stage and
// the latched coordinate, status levels and action strobes coming back.
interface captura_coordenada_if;
   logic       ch7;
   logic       ch6;
   logic [2:0] col_sw;
   logic [2:0] lin_sw;
   logic       btn_confirma;
   logic [2:0] col_out;
   logic [2:0] lin_out;
   logic       en_display;
   logic       valido;
   logic       posicionar;
   logic       disparo;
   logic       erro;

   // Board side: drives switches and button, observes the captured coordinate.
   modport master (
      output ch7, ch6, col_sw, lin_sw, btn_confirma,
      input  col_out, lin_out, en_display, valido, posicionar, disparo, erro
   );

   // Capture stage side.
   modport slave (
      input  ch7, ch6, col_sw, lin_sw, btn_confirma,
      output col_out, lin_out, en_display, valido, posicionar, disparo, erro
   );
endinterface

// File: rtl/captura_coordenada.sv
// Input-capture stage for the board-game coordinate path: synchronises the
// switches and confirm button, debounces press and release, range-checks the
// column/row code against the grid and latches an accepted coordinate.
module captura_coordenada #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int GRID            = 5
) (
   input logic                 clk,
   input logic                 reset,
   captura_coordenada_if.slave bus
);

   localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_UM     = CW'(1);
   localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] DESLIGADO = 3'd0;
   localparam logic [2:0] ESPERA    = 3'd1;
   localparam logic [2:0] DEB_PRESS = 3'd2;
   localparam logic [2:0] SOLTURA   = 3'd3;
   localparam logic [2:0] DEB_SOLTA = 3'd4;

   // True when a 3-bit code addresses a cell inside the grid.
   function automatic logic no_grid(input logic [2:0] codigo);
      return ({1'b0, codigo} < 4'(GRID));
   endfunction

   // synchroniser stage 0 (*_p0) and stage 1 (*_s)
   logic       btn_p0, ch7_p0, ch6_p0;
   logic [2:0] col_p0, lin_p0;
   logic       btn_s, ch7_s, ch6_s;
   logic [2:0] col_s, lin_s;

   // control state
   logic [2:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ch6_d;
   logic          aceita;

   // registered outputs
   logic [2:0] col_q, lin_q, col_n, lin_n;
   logic       valido_q, erro_q, en_q, pos_q, disp_q;
   logic       valido_n, erro_n, en_n, pos_n, disp_n;

   // Two-flop synchronisers for every asynchronous board input.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_p0 <= 1'b0;
         ch7_p0 <= 1'b0;
         ch6_p0 <= 1'b0;
         col_p0 <= '0;
         lin_p0 <= '0;
         btn_s  <= 1'b0;
         ch7_s  <= 1'b0;
         ch6_s  <= 1'b0;
         col_s  <= '0;
         lin_s  <= '0;
      end else begin
         btn_p0 <= bus.btn_confirma;
         ch7_p0 <= bus.ch7;
         ch6_p0 <= bus.ch6;
         col_p0 <= bus.col_sw;
         lin_p0 <= bus.lin_sw;
         btn_s  <= btn_p0;
         ch7_s  <= ch7_p0;
         ch6_s  <= ch6_p0;
         col_s  <= col_p0;
         lin_s  <= lin_p0;
      end
   end

   // Debounce FSM, capture decision and next values of all outputs.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      col_n    = col_q;
      lin_n    = lin_q;
      valido_n = valido_q;
      erro_n   = erro_q;
      pos_n    = 1'b0;
      disp_n   = 1'b0;
      aceita   = 1'b0;

      if (!ch7_s) begin
         state_n  = DESLIGADO;
         cnt_n    = '0;
         col_n    = '0;
         lin_n    = '0;
         valido_n = 1'b0;
         erro_n   = 1'b0;
      end else begin
         // A mode flip starts a new game phase: forget the held coordinate.
         if ((state != DESLIGADO) && (ch6_s != ch6_d)) begin
            col_n    = '0;
            lin_n    = '0;
            valido_n = 1'b0;
            erro_n   = 1'b0;
         end

         case (state)
            DESLIGADO: begin
               // A button already held at power-up must be released first.
               cnt_n   = '0;
               state_n = btn_s ? SOLTURA : ESPERA;
            end
            ESPERA: begin
               if (btn_s) begin
                  state_n = DEB_PRESS;
                  cnt_n   = CNT_UM;
               end
            end
            DEB_PRESS: begin
               if (!btn_s) begin
                  state_n = ESPERA;
                  cnt_n   = '0;
               end else if (cnt == CNT_ULTIMO) begin
                  state_n = SOLTURA;
                  cnt_n   = '0;
                  aceita  = 1'b1;
               end else begin
                  cnt_n = cnt + CNT_UM;
               end
            end
            SOLTURA: begin
               if (!btn_s) begin
                  state_n = DEB_SOLTA;
                  cnt_n   = CNT_UM;
               end
            end
            DEB_SOLTA: begin
               if (btn_s) begin
                  state_n = SOLTURA;
                  cnt_n   = '0;
               end else if (cnt == CNT_ULTIMO) begin
                  state_n = ESPERA;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CNT_UM;
               end
            end
            default: begin
               state_n = DESLIGADO;
               cnt_n   = '0;
            end
         endcase

         // An accept overrides a simultaneous mode-flip clear.
         if (aceita) begin
            if (no_grid(col_s) && no_grid(lin_s)) begin
               col_n    = col_s;
               lin_n    = lin_s;
               valido_n = 1'b1;
               erro_n   = 1'b0;
               pos_n    = !ch6_s;
               disp_n   = ch6_s;
            end else begin
               erro_n = 1'b1;
            end
         end
      end

      en_n = valido_n & ch7_s;
   end

   // control/output stage: state, counter, latched coordinate and strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= DESLIGADO;
         cnt      <= '0;
         ch6_d    <= 1'b0;
         col_q    <= '0;
         lin_q    <= '0;
         valido_q <= 1'b0;
         erro_q   <= 1'b0;
         en_q     <= 1'b0;
         pos_q    <= 1'b0;
         disp_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ch6_d    <= ch6_s;
         col_q    <= col_n;
         lin_q    <= lin_n;
         valido_q <= valido_n;
         erro_q   <= erro_n;
         en_q     <= en_n;
         pos_q    <= pos_n;
         disp_q   <= disp_n;
      end
   end

   assign bus.col_out    = col_q;
   assign bus.lin_out    = lin_q;
   assign bus.valido     = valido_q;
   assign bus.erro       = erro_q;
   assign bus.en_display = en_q;
   assign bus.posicionar = pos_q;
   assign bus.disparo    = disp_q;

endmodule

// File: tb/tb_captura_coordenada.sv
// Bench for captura_coordenada: directed scenarios plus random press traffic,
// a run-length reference model feeding an event scoreboard and a level history.
module tb_captura_coordenada;

   localparam int D = 4;
   localparam int G = 5;

   typedef struct {
      int       edge_n;
      int       kind;   // 0 posicionar, 1 disparo, 2 erro rising
      bit [2:0] col;
      bit [2:0] lin;
      bit       val;
      bit       err;
   } ev_t;

   typedef struct {
      bit [2:0] col;
      bit [2:0] lin;
      bit       val;
      bit       err;
   } lv_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   edge_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   captura_coordenada_if bus ();

   captura_coordenada #(.DEBOUNCE_CYCLES(D), .GRID(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // reference model state (expressed in raw-sample time)
   ev_t      sb[$];
   lv_t      hist[int];
   bit [2:0] m_col = 0, m_lin = 0;
   bit       m_val = 0, m_err = 0;
   bit       armed = 0, m_pprev = 0, m_ch6prev = 0;
   int       hi = 0, lo = 0;

   // current switch settings
   bit       sw_p = 0, sw_m = 0;
   bit [2:0] sw_c = 0, sw_l = 0;

   task automatic push_ev(input int k, input int kind);
      ev_t e;
      e.edge_n = k + 2;
      e.kind   = kind;
      e.col    = m_col;
      e.lin    = m_lin;
      e.val    = m_val;
      e.err    = m_err;
      sb.push_back(e);
   endtask

   // One raw sample k; its effect is visible on the outputs at edge k+2.
   task automatic model_step(input bit b, input bit p, input bit m,
                             input bit [2:0] c, input bit [2:0] l, input int k);
      lv_t v;
      if (!p) begin
         m_col = 0; m_lin = 0; m_val = 0; m_err = 0;
         armed = 0; hi = 0; lo = 0;
      end else if (!m_pprev) begin
         armed = !b; hi = 0; lo = 0;
      end else begin
         if (m != m_ch6prev) begin
            m_col = 0; m_lin = 0; m_val = 0; m_err = 0;
         end
         if (b) begin
            lo = 0;
            if (hi < 1000) hi++;
            if (armed && hi == D) begin
               armed = 0;
               if (c < G && l < G) begin
                  m_col = c; m_lin = l; m_val = 1; m_err = 0;
                  push_ev(k, m ? 1 : 0);
               end else begin
                  if (!m_err) begin
                     m_err = 1;
                     push_ev(k, 2);
                  end
               end
            end
         end else begin
            hi = 0;
            if (!armed) begin
               lo++;
               if (lo == D) armed = 1;
            end
         end
      end
      m_pprev   = p;
      m_ch6prev = m;
      v.col = m_col; v.lin = m_lin; v.val = m_val; v.err = m_err;
      hist[k + 2] = v;
   endtask

   task automatic step(input bit b);
      bus.btn_confirma = b;
      bus.ch7    = sw_p;
      bus.ch6    = sw_m;
      bus.col_sw = sw_c;
      bus.lin_sw = sw_l;
      if (reset) model_step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, edge_cnt + 1);
      else       model_step(b, sw_p, sw_m, sw_c, sw_l, edge_cnt + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input int n, input bit b);
      repeat (n) step(b);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", nm, edge_cnt, act, exp);
      end
   endtask

   // Outputs {col,lin,valido,erro,en_display} against the model history.
   task automatic check_levels(input string nm);
      lv_t h;
      int  act;
      act = {bus.col_out, bus.lin_out, bus.valido, bus.erro, bus.en_display};
      if (hist.exists(edge_cnt)) begin
         h = hist[edge_cnt];
         chk(nm, act, {h.col, h.lin, h.val, h.err, h.val});
      end
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {bus.col_out, bus.lin_out, bus.valido, bus.erro, bus.en_display,
               bus.posicionar, bus.disparo}, 0);
   endtask

   // Monitor: every strobe or erro rise pops the scoreboard; stale entries are misses.
   logic err_last = 1'b0;
   always @(negedge clk) begin
      bit  er;
      int  kind;
      ev_t e;
      er = (bus.erro === 1'b1) && !err_last;
      err_last = (bus.erro === 1'b1);
      if (bus.posicionar === 1'b1 || bus.disparo === 1'b1 || er) begin
         kind = (bus.posicionar === 1'b1 && bus.disparo === 1'b1) ? 3 :
                (bus.disparo === 1'b1) ? 1 : (bus.posicionar === 1'b1) ? 0 : 2;
         checks++;
         if (sb.size() == 0 || sb[0].edge_n != edge_cnt) begin
            errors++;
            $display("FAIL unexpected_event at edge %0d: kind=%0d col=%0d lin=%0d, none expected here",
                     edge_cnt, kind, bus.col_out, bus.lin_out);
         end else begin
            e = sb.pop_front();
            if (kind != e.kind || bus.col_out !== e.col || bus.lin_out !== e.lin ||
                bus.valido !== e.val || bus.erro !== e.err || bus.en_display !== e.val) begin
               errors++;
               $display("FAIL event at edge %0d: got kind=%0d col=%0d lin=%0d val=%0b err=%0b en=%0b expected kind=%0d col=%0d lin=%0d val=%0b err=%0b en=%0b",
                        edge_cnt, kind, bus.col_out, bus.lin_out, bus.valido, bus.erro,
                        bus.en_display, e.kind, e.col, e.lin, e.val, e.err, e.val);
            end
         end
      end
      while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_event: got nothing at edge %0d expected kind=%0d col=%0d lin=%0d",
                  e.edge_n, e.kind, e.col, e.lin);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit pat[7];
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      // reset state
      reset = 1'b1;
      hold(3, 1'b0);
      chk_zero("reset_state");
      reset = 1'b0;

      // attack capture, held button
      sw_p = 1; sw_m = 1; sw_c = 3; sw_l = 2;
      hold(4, 1'b0);
      hold(10, 1'b1);
      hold(6, 1'b0);
      check_levels("attack_capture");
      chk("attack_col", bus.col_out, 3);

      // mode flip clears, then placement capture
      sw_m = 0; sw_c = 0; sw_l = 4;
      hold(4, 1'b0);
      check_levels("ch6_clear_a");
      chk("ch6_clear_valido", bus.valido, 0);
      hold(5, 1'b1);
      hold(5, 1'b0);
      check_levels("place_capture");

      // out-of-range confirm keeps previous coordinate
      sw_c = 3; sw_l = 1;
      hold(5, 1'b1);
      hold(5, 1'b0);
      sw_c = 5;
      hold(5, 1'b1);
      hold(5, 1'b0);
      check_levels("out_of_range");
      chk("oor_erro", bus.erro, 1);
      chk("oor_col_kept", bus.col_out, 3);
      chk("oor_valido_kept", bus.valido, 1);
      sw_c = 1;
      hold(5, 1'b1);
      hold(5, 1'b0);
      check_levels("valid_after_err");
      chk("recover_col", bus.col_out, 1);

      // bouncing press, then re-arm boundary
      sw_c = 2; sw_l = 2;
      foreach (pat[i]) step(pat[i]);
      check_levels("bounce_nocapture");
      hold(4, 1'b1);
      hold(3, 1'b0);
      hold(6, 1'b1);
      hold(4, 1'b0);
      hold(4, 1'b1);
      hold(5, 1'b0);
      check_levels("rearm");

      // power lost mid-press
      sw_c = 4; sw_l = 0;
      hold(2, 1'b1);
      sw_p = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         check_levels("power_off_ramp");
      end
      chk_zero("power_off_zero");
      sw_p = 1;
      hold(8, 1'b1);
      hold(4, 1'b0);
      hold(4, 1'b1);
      hold(5, 1'b0);
      check_levels("power_back");

      // mode toggle with a coordinate held
      sw_m = ~sw_m;
      hold(4, 1'b0);
      check_levels("ch6_clear_b");
      chk_zero("ch6_clear_zero");

      // reset while waiting for release
      sw_c = 2; sw_l = 3;
      hold(6, 1'b1);
      reset = 1'b1;
      step(1'b1);
      chk_zero("reset_mid_soltura");
      reset = 1'b0;
      hold(6, 1'b1);
      hold(4, 1'b0);
      hold(4, 1'b1);
      hold(5, 1'b0);
      check_levels("after_reset");

      // random traffic
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            sw_c = 3'($urandom_range(0, 4));
            sw_l = 3'($urandom_range(0, 4));
         end else begin
            sw_c = 3'($urandom_range(0, 7));
            sw_l = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 4) == 0) sw_m = ~sw_m;
         if ($urandom_range(0, 9) == 0) begin
            sw_p = 0;
            hold(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            sw_p = 1;
         end
         hold(int'($urandom_range(1, 8)), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            hold(1, 1'b0);
            hold(int'($urandom_range(1, 6)), 1'b1);
         end
         hold(int'($urandom_range(1, 7)), 1'b0);
         check_levels("random");
      end

      hold(8, 1'b0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
